// File: rtl/graph_path_planner.sv
// Single-source shortest-path planner (Dijkstra, one SELECT or RELAX step per cycle)
// over a symmetric weight matrix. Define PATH_PLAN_COST_EN to add the path_cost output.
module graph_path_planner #(
    parameter int NODES    = 26,
    parameter int NODE_W   = 5,
    parameter int WT_W     = 4,
    parameter int DIST_W   = 8,
    parameter int MAX_PATH = 10
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         cfg_we,
    input  logic [NODE_W-1:0]            cfg_a,
    input  logic [NODE_W-1:0]            cfg_b,
    input  logic [WT_W-1:0]              cfg_wt,
    input  logic                         start,
    input  logic [NODE_W-1:0]            s_node,
    input  logic [NODE_W-1:0]            e_node,
    output logic                         busy,
    output logic                         done,
    output logic                         unreachable,
    output logic                         truncated,
    output logic [NODE_W-1:0]            path_len,
    output logic [MAX_PATH*NODE_W-1:0]   final_path
`ifdef PATH_PLAN_COST_EN
    ,
    output logic [DIST_W-1:0]            path_cost
`endif
);

    localparam logic [NODE_W-1:0] NODES_L = NODE_W'(NODES);
    localparam logic [NODE_W-1:0] LAST_L  = NODE_W'(NODES - 1);
    localparam logic [NODE_W-1:0] MAXP_L  = NODE_W'(MAX_PATH);
    localparam logic [DIST_W-1:0] INF_L   = {DIST_W{1'b1}};

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_INIT   = 3'd1,
        ST_SELECT = 3'd2,
        ST_RELAX  = 3'd3,
        ST_TRACE  = 3'd4,
        ST_FINISH = 3'd5
    } state_t;

    state_t                        state_q, state_d;
    logic [WT_W-1:0]               wt_q   [NODES][NODES];
    logic [WT_W-1:0]               wt_d   [NODES][NODES];
    logic [DIST_W-1:0]             dist_q [NODES];
    logic [DIST_W-1:0]             dist_d [NODES];
    logic [NODE_W-1:0]             par_q  [NODES];
    logic [NODE_W-1:0]             par_d  [NODES];
    logic [NODES-1:0]              vis_q, vis_d;
    logic [NODE_W-1:0]             s_q, s_d, e_q, e_d;
    logic [NODE_W-1:0]             mi_q, mi_d, j_q, j_d;
    logic [NODE_W-1:0]             cur_q, cur_d, cnt_q, cnt_d;
    logic [MAX_PATH*NODE_W-1:0]    buf_q, buf_d;
    logic                          busy_q, busy_d, done_q, done_d;
    logic                          unr_q, unr_d, trunc_q, trunc_d;
    logic [NODE_W-1:0]             len_q, len_d;
    logic [MAX_PATH*NODE_W-1:0]    path_q, path_d;
`ifdef PATH_PLAN_COST_EN
    logic [DIST_W-1:0]             cost_q, cost_d;
`endif

    logic [DIST_W-1:0]             sel_dist_s;
    logic [NODE_W-1:0]             sel_idx_s;
    logic                          sel_found_s;
    logic [WT_W-1:0]               rw_s;
    logic [DIST_W:0]               rsum_s;
    logic                          relax_ok_s;

    // Symmetric edge write, blocked while a plan is running or an endpoint is out of range
    always_comb begin
        wt_d = wt_q;
        if (cfg_we && !busy_q && (cfg_a < NODES_L) && (cfg_b < NODES_L)) begin
            wt_d[cfg_a][cfg_b] = cfg_wt;
            wt_d[cfg_b][cfg_a] = cfg_wt;
        end else begin
            wt_d = wt_q;
        end
    end

    // Minimum-distance unvisited node; strict compare keeps the lowest index on ties
    always_comb begin
        sel_dist_s = INF_L;
        sel_idx_s  = {NODE_W{1'b0}};
        for (int i = 0; i < NODES; i++) begin
            if (!vis_q[i] && (dist_q[i] < sel_dist_s)) begin
                sel_dist_s = dist_q[i];
                sel_idx_s  = NODE_W'(i);
            end else begin
                sel_dist_s = sel_dist_s;
            end
        end
        sel_found_s = (sel_dist_s != INF_L);
    end

    // Candidate relaxation of neighbour j through the current node; saturating sums never update
    always_comb begin
        rw_s       = wt_q[mi_q][j_q];
        rsum_s     = {1'b0, dist_q[mi_q]} + {{(DIST_W + 1 - WT_W){1'b0}}, rw_s};
        relax_ok_s = (rw_s != {WT_W{1'b0}}) && !vis_q[j_q] &&
                     (rsum_s < {1'b0, INF_L}) && (rsum_s[DIST_W-1:0] < dist_q[j_q]);
    end

    // Planner FSM next-state and datapath
    always_comb begin
        state_d = state_q;
        dist_d  = dist_q;
        par_d   = par_q;
        vis_d   = vis_q;
        s_d     = s_q;
        e_d     = e_q;
        mi_d    = mi_q;
        j_d     = j_q;
        cur_d   = cur_q;
        cnt_d   = cnt_q;
        buf_d   = buf_q;
        done_d  = 1'b0;
        unr_d   = unr_q;
        trunc_d = trunc_q;
        len_d   = len_q;
        path_d  = path_q;
`ifdef PATH_PLAN_COST_EN
        cost_d  = cost_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    s_d     = s_node;
                    e_d     = e_node;
                    state_d = ST_INIT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_INIT: begin
                buf_d = {(MAX_PATH*NODE_W){1'b1}};
                cnt_d = {NODE_W{1'b0}};
                if ((s_q >= NODES_L) || (e_q >= NODES_L)) begin
                    state_d = ST_FINISH;
                    done_d  = 1'b1;
                    unr_d   = 1'b1;
                    trunc_d = 1'b0;
                    len_d   = {NODE_W{1'b0}};
                    path_d  = {(MAX_PATH*NODE_W){1'b1}};
`ifdef PATH_PLAN_COST_EN
                    cost_d  = INF_L;
`endif
                end else begin
                    for (int i = 0; i < NODES; i++) begin
                        dist_d[i] = INF_L;
                    end
                    vis_d       = {NODES{1'b0}};
                    dist_d[s_q] = {DIST_W{1'b0}};
                    par_d[s_q]  = {NODE_W{1'b0}};
                    state_d     = ST_SELECT;
                end
            end
            ST_SELECT: begin
                if (!sel_found_s) begin
                    cur_d   = e_q;
                    state_d = ST_TRACE;
                end else begin
                    vis_d[sel_idx_s] = 1'b1;
                    mi_d             = sel_idx_s;
                    j_d              = {NODE_W{1'b0}};
                    cur_d            = e_q;
                    state_d          = (sel_idx_s == e_q) ? ST_TRACE : ST_RELAX;
                end
            end
            ST_RELAX: begin
                if (relax_ok_s) begin
                    dist_d[j_q] = rsum_s[DIST_W-1:0];
                    par_d[j_q]  = mi_q;
                end else begin
                    dist_d = dist_q;
                end
                if (j_q == LAST_L) begin
                    state_d = ST_SELECT;
                end else begin
                    j_d = j_q + 1'b1;
                end
            end
            ST_TRACE: begin
                trunc_d = 1'b0;
                if (dist_q[e_q] == INF_L) begin
                    unr_d = 1'b1;
                    len_d = {NODE_W{1'b0}};
                end else begin
                    unr_d = 1'b0;
                    for (int k = 0; k < MAX_PATH; k++) begin
                        buf_d[k*NODE_W +: NODE_W] = (NODE_W'(k) == cnt_q) ? cur_q
                                                                          : buf_q[k*NODE_W +: NODE_W];
                    end
                    cnt_d = cnt_q + 1'b1;
                    len_d = cnt_q + 1'b1;
                    if (cur_q == s_q) begin
                        trunc_d = 1'b0;
                    end else if (cnt_q == (MAXP_L - 1'b1)) begin
                        trunc_d = 1'b1;
                    end else begin
                        cur_d = par_q[cur_q];
                    end
                end
                // Leave TRACE when nothing to emit, the source is written, or the buffer is full
                if ((dist_q[e_q] == INF_L) || (cur_q == s_q) || (cnt_q == (MAXP_L - 1'b1))) begin
                    state_d = ST_FINISH;
                    done_d  = 1'b1;
                    path_d  = buf_d;
`ifdef PATH_PLAN_COST_EN
                    cost_d  = dist_q[e_q];
`endif
                end else begin
                    state_d = ST_TRACE;
                    unr_d   = unr_q;
                    trunc_d = trunc_q;
                    len_d   = len_q;
                end
            end
            ST_FINISH: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // Weight matrix storage
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int a = 0; a < NODES; a++) begin
                for (int b = 0; b < NODES; b++) begin
                    wt_q[a][b] <= {WT_W{1'b0}};
                end
            end
        end else begin
            wt_q <= wt_d;
        end
    end

    // Planner state, working arrays and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            for (int i = 0; i < NODES; i++) begin
                dist_q[i] <= INF_L;
                par_q[i]  <= {NODE_W{1'b0}};
            end
            vis_q   <= {NODES{1'b0}};
            s_q     <= {NODE_W{1'b0}};
            e_q     <= {NODE_W{1'b0}};
            mi_q    <= {NODE_W{1'b0}};
            j_q     <= {NODE_W{1'b0}};
            cur_q   <= {NODE_W{1'b0}};
            cnt_q   <= {NODE_W{1'b0}};
            buf_q   <= {(MAX_PATH*NODE_W){1'b1}};
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            unr_q   <= 1'b0;
            trunc_q <= 1'b0;
            len_q   <= {NODE_W{1'b0}};
            path_q  <= {(MAX_PATH*NODE_W){1'b1}};
`ifdef PATH_PLAN_COST_EN
            cost_q  <= {DIST_W{1'b0}};
`endif
        end else begin
            state_q <= state_d;
            dist_q  <= dist_d;
            par_q   <= par_d;
            vis_q   <= vis_d;
            s_q     <= s_d;
            e_q     <= e_d;
            mi_q    <= mi_d;
            j_q     <= j_d;
            cur_q   <= cur_d;
            cnt_q   <= cnt_d;
            buf_q   <= buf_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            unr_q   <= unr_d;
            trunc_q <= trunc_d;
            len_q   <= len_d;
            path_q  <= path_d;
`ifdef PATH_PLAN_COST_EN
            cost_q  <= cost_d;
`endif
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign unreachable = unr_q;
    assign truncated   = trunc_q;
    assign path_len    = len_q;
    assign final_path  = path_q;
`ifdef PATH_PLAN_COST_EN
    assign path_cost   = cost_q;
`endif

endmodule

// File: doc/graph_path_planner.md
GRAPH_PATH_PLANNER -- requirements
Module: graph_path_planner

Interface
REQ-001 SHALL expose parameters as follows, one per line: name, default, meaning.
- NODES, 26, number of graph nodes.
- NODE_W, 5, node index width; 2^NODE_W > NODES.
- WT_W, 4, edge weight width; weight 0 means no edge.
- DIST_W, 8, distance accumulator width; all-ones means INF.
- MAX_PATH, 10, maximum nodes reported in the path.

REQ-002 SHALL have the following ports, one per line: name, direction, width, meaning.
- clk, in, 1, single clock; all logic is on the rising edge.
- reset, in, 1, asynchronous active-high reset.
- cfg_we, in, 1, edge write strobe.
- cfg_a, in, NODE_W, edge endpoint A.
- cfg_b, in, NODE_W, edge endpoint B.
- cfg_wt, in, WT_W, edge weight.
- start, in, 1, plan request.
- s_node, in, NODE_W, source node.
- e_node, in, NODE_W, destination node.
- busy, out, 1, plan in progress.
- done, out, 1, one-cycle completion pulse.
- unreachable, out, 1, no route found or invalid node given; valid with done.
- truncated, out, 1, route longer than MAX_PATH; valid with done.
- path_len, out, NODE_W, number of valid path entries.
- final_path, out, MAX_PATH*NODE_W, path entries; entry k occupies bits [k*NODE_W +: NODE_W].

Function
REQ-003 SHALL store an NODES x NODES weight matrix; a cfg_we write with busy=0 SHALL write cfg_wt to both [a][b] and [b][a] in one cycle.
REQ-004 SHALL ignore cfg_we when busy=1, or when cfg_a or cfg_b >= NODES.
REQ-005 SHALL accept start only in IDLE, sampling s_node and e_node that cycle; start while busy SHALL be ignored.
REQ-006 SHALL implement the FSM states IDLE, INIT, SELECT, RELAX, TRACE, FINISH:
- IDLE→INIT on an accepted start.
- INIT→SELECT.
- SELECT→RELAX, or →TRACE on termination.
- RELAX→SELECT after the last neighbour.
- TRACE→FINISH.
- FINISH→IDLE.
REQ-007 INIT SHALL, in one cycle, set every dist to INF, clear every visited bit, set dist[s]=0, and clear parent[s].
REQ-008 SELECT SHALL, in one cycle, choose the unvisited node with the minimum finite dist, taking the lowest index on ties, and mark it visited.
REQ-009 SELECT SHALL terminate to TRACE when no unvisited finite node exists, or when the chosen node equals e_node.
REQ-010 RELAX SHALL examine one candidate j per cycle, for j = 0..NODES-1.
REQ-011 If w=[mi][j]≠0, j is unvisited, and dist[mi]+w < dist[j], RELAX SHALL set dist[j]=dist[mi]+w and parent[j]=mi.
REQ-012 Any sum saturating to INF or above SHALL NOT update dist[j].
REQ-013 TRACE SHALL emit one entry per cycle: entry 0 = e_node, then parent links, ending with s_node.
REQ-014 Unused final_path entries SHALL hold 2^NODE_W-1.
REQ-015 If more than MAX_PATH nodes would be emitted, TRACE SHALL stop at MAX_PATH entries and set truncated=1.
REQ-016 If dist[e] = INF, TRACE SHALL emit nothing, set path_len=0 and set unreachable=1.
REQ-017 If s_node or e_node >= NODES, the block SHALL go INIT→FINISH with unreachable=1 and path_len=0.
REQ-018 If s_node == e_node, the result SHALL be path_len=1 and entry 0 = s.
REQ-019 busy SHALL be 1 in every state other than IDLE.
REQ-020 done SHALL pulse for exactly one cycle in FINISH.
REQ-021 final_path, path_len, unreachable and truncated SHALL update only in FINISH and hold until the next FINISH.
REQ-022 Latency from start to done SHALL be ≤ 2 + NODES*(NODES+1) + MAX_PATH + 1 cycles.

Reset
REQ-023 While reset=1, the FSM SHALL be IDLE and busy, done, unreachable, truncated and path_len SHALL be 0.
REQ-024 While reset=1, every final_path entry SHALL be 2^NODE_W-1 and every weight SHALL be 0.
REQ-025 Reset asserted mid-plan SHALL abort the plan with no done pulse.
REQ-026 After reset deasserts, the first accepted start SHALL be honoured.

Configuration
REQ-027 With PATH_PLAN_COST_EN defined, the block SHALL add output path_cost [DIST_W-1:0].
REQ-028 path_cost SHALL equal dist[e] latched in FINISH, is INF when unreachable, and resets to 0.
REQ-029 Without PATH_PLAN_COST_EN, the path_cost port and its register SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-030 The bench SHALL cover these directed scenarios:
- Load edges 0-1:3, 1-2:3, 2-5:3, 5-9:2, 9-8:1, 1-13:3; start s=0 e=9 → done; path 9,5,2,1,0; path_len=5; path_cost=11; unreachable=0.
- Same graph, s=0 e=4 (no edges to 4) → unreachable=1, path_len=0, all entries 31, path_cost=255.
- s=e=13 → path_len=1, entry0=13.
- Ties: add 0-3:6 and 3-5:0 (delete), 0-7:6, 7-5:3 versus 0-1-2-5=9 → lowest-index parent chosen consistently; path_cost=9.
- Chain of 12 nodes, end-to-end plan → truncated=1, path_len=10, entries 11..2.
- Reset mid-RELAX → busy=0 next cycle, no done pulse; weights cleared; start with cfg_we during busy → write ignored; s_node=30 → unreachable=1.
